// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the combinational instruction
// memory and captures the returned word into the IF/ID register.
module fetch_unit #(
    parameter int                WIDTH      = 32,
    parameter logic [WIDTH-1:0]  RESET_PC   = 32'h0000_0000,
    parameter int                IMEM_WORDS = 1024,
    parameter logic [31:0]       NOP_INSTR  = 32'h0000_0013
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             flush,
    input  logic             redirect,
    input  logic [WIDTH-1:0] redirect_pc,
    input  logic             halt_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic [31:0]      imem_rd,
    output logic             if_id_valid,
    output logic [31:0]      if_id_instr,
    output logic [WIDTH-1:0] if_id_pc,
    output logic [WIDTH-1:0] if_id_pc_plus4,
    output logic             fetch_err,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_e;

    // One extra bit so the byte limit itself is representable for any WIDTH.
    localparam logic [WIDTH:0] PC_LIMIT = (WIDTH+1)'(IMEM_WORDS * 4);

    state_e           state_q;
    logic [WIDTH-1:0] pc_q;
    logic             valid_q;
    logic [31:0]      instr_q;
    logic [WIDTH-1:0] id_pc_q;
    logic [WIDTH-1:0] id_pc4_q;
    logic             err_q;

    logic [WIDTH-1:0] pc_seq_d;
    logic             pc_out_of_range_d;
    logic             redir_misaligned_d;

    // Sequential next PC and the fault conditions checked before any capture.
    always_comb begin
        pc_seq_d           = pc_q + {{(WIDTH-3){1'b0}}, 3'd4};
        pc_out_of_range_d  = ({1'b0, pc_q} >= PC_LIMIT);
        redir_misaligned_d = (redirect_pc[1:0] != 2'b00);
    end

    // FSM, program counter and IF/ID register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_BOOT;
            pc_q     <= RESET_PC;
            valid_q  <= 1'b0;
            instr_q  <= NOP_INSTR;
            id_pc_q  <= {WIDTH{1'b0}};
            id_pc4_q <= {WIDTH{1'b0}};
            err_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_BOOT: begin
                    state_q <= ST_RUN;
                end
                ST_RUN: begin
                    if (halt_req) begin
                        state_q <= ST_HALT;
                        valid_q <= 1'b0;
                        instr_q <= NOP_INSTR;
                    end else if (redirect && redir_misaligned_d) begin
                        err_q   <= 1'b1;
                        state_q <= ST_HALT;
                        valid_q <= 1'b0;
                        instr_q <= NOP_INSTR;
                    end else if (redirect) begin
                        // The word on imem_rd is wrong-path: drop it even if stalled.
                        pc_q    <= redirect_pc;
                        valid_q <= 1'b0;
                        instr_q <= NOP_INSTR;
                    end else if (pc_out_of_range_d) begin
                        err_q   <= 1'b1;
                        state_q <= ST_HALT;
                        valid_q <= 1'b0;
                        instr_q <= NOP_INSTR;
                    end else if (stall) begin
                        pc_q <= pc_q;
                    end else if (flush) begin
                        valid_q <= 1'b0;
                        instr_q <= NOP_INSTR;
                        pc_q    <= pc_seq_d;
                    end else begin
                        valid_q  <= 1'b1;
                        instr_q  <= imem_rd;
                        id_pc_q  <= pc_q;
                        id_pc4_q <= pc_seq_d;
                        pc_q     <= pc_seq_d;
                    end
                end
                ST_HALT: begin
                    valid_q <= 1'b0;
                    instr_q <= NOP_INSTR;
                end
                default: begin
                    state_q <= ST_HALT;
                    valid_q <= 1'b0;
                    instr_q <= NOP_INSTR;
                end
            endcase
        end
    end

    assign imem_addr      = pc_q;
    assign if_id_valid    = valid_q;
    assign if_id_instr    = instr_q;
    assign if_id_pc       = id_pc_q;
    assign if_id_pc_plus4 = id_pc4_q;
    assign fetch_err      = err_q;
    assign state          = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: vector table plus hand-written corner
// sequences, expected values queued at drive time and popped after the edge.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        halt_req = 1'b0;
    logic [31:0] imem_addr;
    logic [31:0] imem_rd;
    logic        if_id_valid;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc_plus4;
    logic        fetch_err;
    logic [1:0]  state;

    localparam logic [31:0] NOP = 32'h0000_0013;

    fetch_unit dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .redirect(redirect), .redirect_pc(redirect_pc), .halt_req(halt_req),
        .imem_addr(imem_addr), .imem_rd(imem_rd),
        .if_id_valid(if_id_valid), .if_id_instr(if_id_instr),
        .if_id_pc(if_id_pc), .if_id_pc_plus4(if_id_pc_plus4),
        .fetch_err(fetch_err), .state(state)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:1023];
    always_comb begin
        if (imem_addr < 32'h0000_1000) imem_rd = mem[imem_addr[11:2]];
        else                           imem_rd = 32'hDEAD_BEEF;
    end

    typedef struct packed {
        logic        rst;
        logic        stall;
        logic        flush;
        logic        redir;
        logic [31:0] rpc;
        logic        halt;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_instr;
        logic [31:0] e_pc;
        logic [1:0]  e_state;
        logic        e_err;
    } vec_t;

    vec_t exp_q[$];
    vec_t tbl[15];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   vidx  = 0;

    function automatic vec_t mk(input logic rst, input logic st, input logic fl,
                                input logic rd, input logic [31:0] rpc, input logic hl,
                                input logic [31:0] ea, input logic ev,
                                input logic [31:0] ei, input logic [31:0] ep,
                                input logic [1:0] es, input logic ee);
        vec_t v;
        v.rst = rst; v.stall = st; v.flush = fl; v.redir = rd; v.rpc = rpc; v.halt = hl;
        v.e_addr = ea; v.e_valid = ev; v.e_instr = ei; v.e_pc = ep;
        v.e_state = es; v.e_err = ee;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s vec %0d: got %h expected %h", name, idx, act, expv);
        end
    endtask

    task automatic apply(input vec_t v);
        vec_t e;
        @(negedge clk);
        reset = v.rst; stall = v.stall; flush = v.flush;
        redirect = v.redir; redirect_pc = v.rpc; halt_req = v.halt;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk("imem_addr", vidx, imem_addr, e.e_addr);
        chk("state", vidx, {30'd0, state}, {30'd0, e.e_state});
        chk("fetch_err", vidx, {31'd0, fetch_err}, {31'd0, e.e_err});
        chk("valid", vidx, {31'd0, if_id_valid}, {31'd0, e.e_valid});
        chk("instr", vidx, if_id_instr, e.e_instr);
        if (e.e_valid || e.e_state == 2'd0) begin
            chk("if_id_pc", vidx, if_id_pc, e.e_pc);
            chk("pc_plus4", vidx, if_id_pc_plus4, e.e_valid ? e.e_pc + 32'd4 : 32'd0);
        end
        vidx++;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'hC000_0000 + 32'(i);
        mem[0] = 32'h0010_0093;
        mem[1] = 32'h00A0_0113;
        mem[2] = 32'h0140_0193;
        mem[3] = 32'h0010_9513;

        //            rst st fl rd rpc          hl addr          v  instr          pc           s     err
        tbl[0]  = mk(1, 0, 0, 0, 32'h0,       0, 32'h0,       0, NOP,          32'h0,       2'd0, 0);
        tbl[1]  = mk(1, 1, 1, 1, 32'h40,      1, 32'h0,       0, NOP,          32'h0,       2'd0, 0);
        tbl[2]  = mk(0, 0, 0, 0, 32'h0,       0, 32'h0,       0, NOP,          32'h0,       2'd1, 0);
        tbl[3]  = mk(0, 0, 0, 0, 32'h0,       0, 32'h4,       1, 32'h00100093, 32'h0,       2'd1, 0);
        tbl[4]  = mk(0, 0, 0, 0, 32'h0,       0, 32'h8,       1, 32'h00A00113, 32'h4,       2'd1, 0);
        tbl[5]  = mk(0, 1, 0, 0, 32'h0,       0, 32'h8,       1, 32'h00A00113, 32'h4,       2'd1, 0);
        tbl[6]  = mk(0, 1, 0, 0, 32'h0,       0, 32'h8,       1, 32'h00A00113, 32'h4,       2'd1, 0);
        tbl[7]  = mk(0, 0, 0, 0, 32'h0,       0, 32'hC,       1, 32'h01400193, 32'h8,       2'd1, 0);
        tbl[8]  = mk(0, 1, 1, 0, 32'h0,       0, 32'hC,       1, 32'h01400193, 32'h8,       2'd1, 0);
        tbl[9]  = mk(0, 0, 1, 0, 32'h0,       0, 32'h10,      0, NOP,          32'h0,       2'd1, 0);
        tbl[10] = mk(0, 0, 0, 0, 32'h0,       0, 32'h14,      1, 32'hC0000004, 32'h10,      2'd1, 0);
        tbl[11] = mk(0, 1, 0, 1, 32'h10,      0, 32'h10,      0, NOP,          32'h0,       2'd1, 0);
        tbl[12] = mk(0, 0, 0, 0, 32'h0,       0, 32'h14,      1, 32'hC0000004, 32'h10,      2'd1, 0);
        tbl[13] = mk(0, 0, 0, 0, 32'h0,       0, 32'h18,      1, 32'hC0000005, 32'h14,      2'd1, 0);
        // halt_req outranks a misaligned redirect: halt without error
        tbl[14] = mk(0, 0, 0, 1, 32'h12,      1, 32'h18,      0, NOP,          32'h0,       2'd2, 0);

        for (int i = 0; i < 15; i++) apply(tbl[i]);

        // Misaligned redirect: sticky error, HALT ignores everything but reset.
        apply(mk(1, 0, 0, 0, 32'h0,  0, 32'h0, 0, NOP,          32'h0, 2'd0, 0));
        apply(mk(0, 0, 0, 0, 32'h0,  0, 32'h0, 0, NOP,          32'h0, 2'd1, 0));
        apply(mk(0, 0, 0, 0, 32'h0,  0, 32'h4, 1, 32'h00100093, 32'h0, 2'd1, 0));
        apply(mk(0, 0, 0, 1, 32'h12, 0, 32'h4, 0, NOP,          32'h0, 2'd2, 1));
        for (int i = 0; i < 10; i++) begin
            logic [3:0] r;
            r = 4'($urandom);
            apply(mk(0, r[0], r[1], r[2] | (i[0] == 1'b0), $urandom & 32'hFFC, r[3] ^ i[0],
                     32'h4, 0, NOP, 32'h0, 2'd2, 1));
        end
        apply(mk(1, 0, 0, 0, 32'h0,  0, 32'h0, 0, NOP, 32'h0, 2'd0, 0));

        // Last legal word is captured, the next PC is out of range.
        apply(mk(0, 0, 0, 0, 32'h0,   0, 32'h0,    0, NOP,          32'h0,   2'd1, 0));
        apply(mk(0, 0, 0, 1, 32'hFFC, 0, 32'hFFC,  0, NOP,          32'h0,   2'd1, 0));
        apply(mk(0, 0, 0, 0, 32'h0,   0, 32'h1000, 1, 32'hC00003FF, 32'hFFC, 2'd1, 0));
        apply(mk(0, 0, 0, 0, 32'h0,   0, 32'h1000, 0, NOP,          32'h0,   2'd2, 1));
        apply(mk(0, 0, 0, 0, 32'h0,   0, 32'h1000, 0, NOP,          32'h0,   2'd2, 1));

        // Mid-operation reset from RUN after a capture.
        apply(mk(1, 0, 0, 0, 32'h0, 0, 32'h0, 0, NOP,          32'h0, 2'd0, 0));
        apply(mk(0, 0, 0, 0, 32'h0, 0, 32'h0, 0, NOP,          32'h0, 2'd1, 0));
        apply(mk(0, 0, 0, 0, 32'h0, 0, 32'h4, 1, 32'h00100093, 32'h0, 2'd1, 0));
        apply(mk(1, 0, 0, 1, 32'h8, 0, 32'h0, 0, NOP,          32'h0, 2'd0, 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage that sits directly upstream of the combinational instruction memory.
- Owns the program counter and drives the memory byte address.
- Captures the returned instruction word into an IF/ID register with a valid bit, which feeds the decoder.
- Handles stall, flush, branch/jump redirect and halt, and detects misaligned and out-of-range fetch addresses.

Parameters:
WIDTH, 32, PC / address width in bits
RESET_PC, 32'h0000_0000, PC value loaded on reset
IMEM_WORDS, 1024, instruction memory depth in 32-bit words; legal fetch range is 0 to IMEM_WORDS*4-1
NOP_INSTR, 32'h0000_0013, bubble encoding (addi x0,x0,0)

Ports:
clk  in  1  single system clock; all state updates on its rising edge
reset  in  1  synchronous, active-high reset
stall  in  1  hold PC and IF/ID contents
flush  in  1  replace the next IF/ID capture with a bubble
redirect  in  1  load redirect_pc (taken branch / jal / jalr)
redirect_pc  in  WIDTH  redirect target byte address
halt_req  in  1  request to stop fetching
imem_addr  out  WIDTH  byte address to instruction memory; equals pc combinationally
imem_rd  in  32  instruction word returned by memory in the same cycle
if_id_valid  out  1  IF/ID holds a real instruction
if_id_instr  out  32  fetched instruction
if_id_pc  out  WIDTH  address of if_id_instr
if_id_pc_plus4  out  WIDTH  if_id_pc + 4
fetch_err  out  1  sticky error flag (misaligned redirect or out-of-range PC)
state  out  2  FSM state: 0 BOOT, 1 RUN, 2 HALT

Behaviour:
Reset:
- Values: pc=RESET_PC, state=BOOT, if_id_valid=0, if_id_instr=NOP_INSTR, if_id_pc=0, if_id_pc_plus4=0, fetch_err=0.
- reset overrides every other input in the same edge.
- Reset asserted mid-operation restores exactly these values in one cycle.

BOOT:
- One cycle only: no capture, if_id_valid stays 0, pc holds.
- Goes unconditionally to RUN.

RUN, evaluated per edge in this priority order:
1. halt_req -> HALT. Bubble in IF/ID (valid=0, instr=NOP_INSTR); pc held.
2. redirect with redirect_pc[1:0]!=0 -> fetch_err=1, HALT, bubble; pc unchanged.
3. redirect (aligned) -> pc<=redirect_pc; IF/ID bubble regardless of stall/flush. The wrong-path instruction is discarded.
4. pc >= IMEM_WORDS*4 -> fetch_err=1, HALT, bubble; pc held. This is checked before any capture, so an illegal word is never marked valid.
5. stall -> pc and all IF/ID fields hold. A flush asserted together with stall is ignored; stall wins.
6. flush -> IF/ID bubble; pc<=pc+4.
7. Otherwise -> IF/ID<={valid=1, instr=imem_rd, pc=pc, pc_plus4=pc+4}; pc<=pc+4.

HALT:
- pc held, if_id_valid=0, if_id_instr=NOP_INSTR.
- All inputs except reset are ignored; only reset exits HALT.

Arithmetic and timing:
- pc+4 is computed modulo 2^WIDTH; wrap is never reached in legal operation because of the range check.
- Fetch latency: an instruction at pc appears on IF/ID outputs one clock after pc is presented on imem_addr.
- Throughput: one instruction per cycle when not stalled.
- fetch_err is cleared only by reset.

Test Plan:
- Memory preloaded with 00100093, 00A00113, 01400193, 00109513. Release reset:
  - Cycle 1: state=BOOT, valid=0.
  - Cycle 2: state=RUN, imem_addr=0.
  - Cycle 3: if_id_instr=00100093, if_id_pc=0, pc_plus4=4, valid=1.
  - Cycle 4: instr=00A00113, if_id_pc=4.
- stall high for 2 cycles while imem_addr=8 -> imem_addr stays 8 and IF/ID holds pc=4/00A00113 both cycles; after release, IF/ID gets pc=8/01400193.
- redirect=1, redirect_pc=0x10, with stall=1 in the same cycle -> next cycle imem_addr=0x10, valid=0, instr=00000013; following cycle if_id_pc=0x10, valid=1.
- flush alone with imem_addr=0x0C -> IF/ID bubble (valid=0, NOP) and imem_addr=0x10. Repeat with flush+stall -> IF/ID unchanged, imem_addr stays 0x0C.
- redirect_pc=0x12 -> fetch_err=1, state=2, imem_addr unchanged, valid=0 for 10 further cycles with redirect/halt toggling; then reset -> fetch_err=0, state=0.
- With IMEM_WORDS=1024: redirect to 0xFFC -> captures pc=0xFFC with valid=1; next cycle pc=0x1000 -> fetch_err=1, state=HALT, valid=0.
